// File: rtl/mcpu_core_scoreboard_pkg.sv
// rtl/mcpu_core_scoreboard_pkg.sv - shared constants for the register/predicate scoreboard
package mcpu_core_scoreboard_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PREDS     = 3;
  localparam int REG_NUM_W     = 5;
  localparam int PRED_NUM_W    = 2;
  localparam logic [PRED_NUM_W-1:0] PRED_ALWAYS = 2'd3;

  // All-ones countdown value marks a sticky entry released only by writeback or flush.
  function automatic int lat_long(input int lat_w);
    return (1 << lat_w) - 1;
  endfunction

endpackage

// File: rtl/mcpu_core_sb_counter.sv
// rtl/mcpu_core_sb_counter.sv - one latency countdown with flush > load > clear > decrement priority
module mcpu_core_sb_counter
  import mcpu_core_scoreboard_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             clear,
  output logic             busy
);

  localparam logic [LAT_W-1:0] LAT_LONG = LAT_W'(lat_long(LAT_W));

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0 && cnt != LAT_LONG) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/mcpu_core_scoreboard.sv
// rtl/mcpu_core_scoreboard.sv - multi-lane register/predicate scoreboard driving the decode dependency stall
module mcpu_core_scoreboard
  import mcpu_core_scoreboard_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LAT_W     = 3,
  parameter int NUM_WB    = 2
) (
  input  logic                       clkrst_core_clk,
  input  logic                       clkrst_core_rst_n,
  input  logic [NUM_LANES-1:0]       d2sb_valid,
  input  logic [5*NUM_LANES-1:0]     d2sb_rs_num,
  input  logic [5*NUM_LANES-1:0]     d2sb_rt_num,
  input  logic [NUM_LANES-1:0]       d2sb_depend_rs,
  input  logic [NUM_LANES-1:0]       d2sb_depend_rt,
  input  logic [2*NUM_LANES-1:0]     d2sb_pred_sel,
  input  logic [5*NUM_LANES-1:0]     d2sb_rd_num,
  input  logic [NUM_LANES-1:0]       d2sb_rd_we,
  input  logic [NUM_LANES-1:0]       d2sb_pred_we,
  input  logic [LAT_W*NUM_LANES-1:0] d2sb_lat,
  input  logic                       issue_req,
  input  logic [NUM_WB-1:0]          wb_clr_valid,
  input  logic [5*NUM_WB-1:0]        wb_clr_num,
  input  logic [NUM_WB-1:0]          wb_clr_pred,
  input  logic                       flush,
  output logic                       dep_stall,
  output logic                       waw_conflict,
  output logic [31:0]                sb_reg_busy,
  output logic [2:0]                 sb_pred_busy,
  output logic                       issue_fire
);

  logic [NUM_ARCH_REGS-1:0] reg_busy;
  logic [NUM_PREDS-1:0]     pred_busy;
  logic [3:0]               pred_busy_ext;

  logic [NUM_ARCH_REGS-1:0] reg_load, reg_clr;
  logic [LAT_W-1:0]         reg_val [NUM_ARCH_REGS];
  logic [NUM_PREDS-1:0]     pred_load, pred_clr;
  logic [LAT_W-1:0]         pred_val [NUM_PREDS];

  // Predicate 3 is the always-true guard and reads as permanently free.
  assign pred_busy_ext = {1'b0, pred_busy};

  always_comb begin
    dep_stall = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (d2sb_valid[l]) begin
        if (d2sb_depend_rs[l] && reg_busy[d2sb_rs_num[l*5 +: 5]]) dep_stall = 1'b1;
        if (d2sb_depend_rt[l] && reg_busy[d2sb_rt_num[l*5 +: 5]]) dep_stall = 1'b1;
        if (pred_busy_ext[d2sb_pred_sel[l*2 +: 2]])               dep_stall = 1'b1;
        if (d2sb_rd_we[l] && reg_busy[d2sb_rd_num[l*5 +: 5]])     dep_stall = 1'b1;
        if (d2sb_pred_we[l] && pred_busy_ext[d2sb_rd_num[l*5 +: 2]]) dep_stall = 1'b1;
      end
    end
  end

  // Writes to predicate 3 are discarded, so two of them never collide.
  always_comb begin
    waw_conflict = 1'b0;
    for (int a = 0; a < NUM_LANES; a++) begin
      for (int b = a + 1; b < NUM_LANES; b++) begin
        if (d2sb_valid[a] && d2sb_valid[b]) begin
          if (d2sb_rd_we[a] && d2sb_rd_we[b] &&
              d2sb_rd_num[a*5 +: 5] == d2sb_rd_num[b*5 +: 5])
            waw_conflict = 1'b1;
          if (d2sb_pred_we[a] && d2sb_pred_we[b] &&
              d2sb_rd_num[a*5 +: 2] == d2sb_rd_num[b*5 +: 2] &&
              d2sb_rd_num[a*5 +: 2] != PRED_ALWAYS)
            waw_conflict = 1'b1;
        end
      end
    end
  end

  assign issue_fire = issue_req & ~dep_stall & ~waw_conflict;

  always_comb begin
    reg_load  = '0;
    reg_clr   = '0;
    pred_load = '0;
    pred_clr  = '0;
    for (int r = 0; r < NUM_ARCH_REGS; r++) reg_val[r] = '0;
    for (int p = 0; p < NUM_PREDS; p++) pred_val[p] = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_clr_valid[k]) begin
        if (!wb_clr_pred[k]) begin
          reg_clr[wb_clr_num[k*5 +: 5]] = 1'b1;
        end else if (wb_clr_num[k*5 +: 2] != PRED_ALWAYS) begin
          pred_clr[wb_clr_num[k*5 +: 2]] = 1'b1;
        end
      end
    end
    // A zero latency means the result is bypassable at once and needs no entry.
    for (int l = 0; l < NUM_LANES; l++) begin
      if (issue_fire && d2sb_valid[l] && d2sb_lat[l*LAT_W +: LAT_W] != '0) begin
        if (d2sb_rd_we[l]) begin
          reg_load[d2sb_rd_num[l*5 +: 5]] = 1'b1;
          reg_val[d2sb_rd_num[l*5 +: 5]]  = d2sb_lat[l*LAT_W +: LAT_W];
        end
        if (d2sb_pred_we[l] && d2sb_rd_num[l*5 +: 2] != PRED_ALWAYS) begin
          pred_load[d2sb_rd_num[l*5 +: 2]] = 1'b1;
          pred_val[d2sb_rd_num[l*5 +: 2]]  = d2sb_lat[l*LAT_W +: LAT_W];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_ARCH_REGS; r++) begin : g_reg_cnt
    mcpu_core_sb_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clkrst_core_clk),
      .rst_n    (clkrst_core_rst_n),
      .flush    (flush),
      .load     (reg_load[r]),
      .load_val (reg_val[r]),
      .clear    (reg_clr[r]),
      .busy     (reg_busy[r])
    );
  end

  for (genvar p = 0; p < NUM_PREDS; p++) begin : g_pred_cnt
    mcpu_core_sb_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clkrst_core_clk),
      .rst_n    (clkrst_core_rst_n),
      .flush    (flush),
      .load     (pred_load[p]),
      .load_val (pred_val[p]),
      .clear    (pred_clr[p]),
      .busy     (pred_busy[p])
    );
  end

  assign sb_reg_busy  = reg_busy;
  assign sb_pred_busy = pred_busy;

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// tb/tb_mcpu_core_scoreboard.sv - self-checking bench for the register/predicate scoreboard
module tb_mcpu_core_scoreboard;

  localparam int NL = 4;
  localparam int LW = 3;
  localparam int NW = 2;
  localparam int LONG = 7;
  localparam int STICKY = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst_n;
  logic [NL-1:0]    valid, dep_rs, dep_rt, rd_we, pred_we;
  logic [5*NL-1:0]  rs, rt, rd;
  logic [2*NL-1:0]  psel;
  logic [LW*NL-1:0] lat;
  logic             issue_req, flush;
  logic [NW-1:0]    wbv, wbp;
  logic [5*NW-1:0]  wbn;
  logic             dep_stall, waw_conflict, issue_fire;
  logic [31:0]      sb_reg_busy;
  logic [2:0]       sb_pred_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: each target records the first cycle at which it is free again.
  int rel_r [32];
  int rel_p [3];
  int cyc;

  always #5 clk = ~clk;

  mcpu_core_scoreboard #(.NUM_LANES(NL), .LAT_W(LW), .NUM_WB(NW)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .d2sb_valid        (valid),
    .d2sb_rs_num       (rs),
    .d2sb_rt_num       (rt),
    .d2sb_depend_rs    (dep_rs),
    .d2sb_depend_rt    (dep_rt),
    .d2sb_pred_sel     (psel),
    .d2sb_rd_num       (rd),
    .d2sb_rd_we        (rd_we),
    .d2sb_pred_we      (pred_we),
    .d2sb_lat          (lat),
    .issue_req         (issue_req),
    .wb_clr_valid      (wbv),
    .wb_clr_num        (wbn),
    .wb_clr_pred       (wbp),
    .flush             (flush),
    .dep_stall         (dep_stall),
    .waw_conflict      (waw_conflict),
    .sb_reg_busy       (sb_reg_busy),
    .sb_pred_busy      (sb_pred_busy),
    .issue_fire        (issue_fire)
  );

  task automatic clear_inputs();
    valid = '0; dep_rs = '0; dep_rt = '0; rd_we = '0; pred_we = '0;
    rs = '0; rt = '0; rd = '0; psel = '1; lat = '0;
    issue_req = 1'b0; flush = 1'b0; wbv = '0; wbp = '0; wbn = '0;
  endtask

  task automatic set_lane(input int l, input int r_s, input bit d_s, input int r_t, input bit d_t,
                          input int ps, input int r_d, input bit we, input bit pwe, input int lt);
    valid[l] = 1'b1;
    rs[l*5 +: 5] = r_s[4:0];  dep_rs[l] = d_s;
    rt[l*5 +: 5] = r_t[4:0];  dep_rt[l] = d_t;
    psel[l*2 +: 2] = ps[1:0];
    rd[l*5 +: 5] = r_d[4:0];  rd_we[l] = we;  pred_we[l] = pwe;
    lat[l*LW +: LW] = lt[LW-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mb_r(input int r);
    return rel_r[r] > cyc;
  endfunction

  function automatic bit mb_p(input int p);
    if (p >= 3) return 1'b0;
    return rel_p[p] > cyc;
  endfunction

  task automatic model_reset();
    foreach (rel_r[i]) rel_r[i] = 0;
    foreach (rel_p[i]) rel_p[i] = 0;
    cyc = 0;
  endtask

  task automatic model_eval(output bit st, output bit w, output bit f,
                            output logic [31:0] eb, output logic [2:0] ep);
    int tgt[$];
    int key;
    st = 1'b0;
    w  = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (valid[l]) begin
        if (dep_rs[l] && mb_r(int'(rs[l*5 +: 5]))) st = 1'b1;
        if (dep_rt[l] && mb_r(int'(rt[l*5 +: 5]))) st = 1'b1;
        if (mb_p(int'(psel[l*2 +: 2]))) st = 1'b1;
        if (rd_we[l] && mb_r(int'(rd[l*5 +: 5]))) st = 1'b1;
        if (pred_we[l] && mb_p(int'(rd[l*5 +: 2]))) st = 1'b1;
        if (rd_we[l]) begin
          key = int'(rd[l*5 +: 5]);
          foreach (tgt[i]) if (tgt[i] == key) w = 1'b1;
          tgt.push_back(key);
        end
        if (pred_we[l] && rd[l*5 +: 2] != 2'd3) begin
          key = 100 + int'(rd[l*5 +: 2]);
          foreach (tgt[i]) if (tgt[i] == key) w = 1'b1;
          tgt.push_back(key);
        end
      end
    end
    f = issue_req && !st && !w;
    for (int r = 0; r < 32; r++) eb[r] = mb_r(r);
    for (int p = 0; p < 3; p++) ep[p] = mb_p(p);
  endtask

  task automatic model_commit(input bit f);
    int c;
    int lt;
    c = cyc;
    if (flush) begin
      foreach (rel_r[i]) rel_r[i] = c + 1;
      foreach (rel_p[i]) rel_p[i] = c + 1;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wbv[k]) begin
          if (!wbp[k]) rel_r[wbn[k*5 +: 5]] = c + 1;
          else if (wbn[k*5 +: 2] != 2'd3) rel_p[wbn[k*5 +: 2]] = c + 1;
        end
      end
      if (f) begin
        for (int l = 0; l < NL; l++) begin
          lt = int'(lat[l*LW +: LW]);
          if (valid[l] && lt != 0) begin
            if (rd_we[l]) rel_r[rd[l*5 +: 5]] = (lt == LONG) ? STICKY : c + lt + 1;
            if (pred_we[l] && rd[l*5 +: 2] != 2'd3)
              rel_p[rd[l*5 +: 2]] = (lt == LONG) ? STICKY : c + lt + 1;
          end
        end
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_reg_busy !== 32'h0 || sb_pred_busy !== 3'h0 || dep_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%h pred=%h stall=%b, required 0/0/0", sb_reg_busy, sb_pred_busy, dep_stall);
    end
    rst_n = 1'b1;
    tick();
    set_lane(0, 0, 0, 0, 0, 3, 3, 1, 0, LONG);
    set_lane(1, 0, 0, 0, 0, 3, 4, 1, 0, 5);
    issue_req = 1'b1;
    tick();
    clear_inputs();
    set_lane(2, 3, 1, 0, 0, 3, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dep_stall !== 1'b1 || sb_reg_busy !== 32'h18) begin
      errors++;
      $display("FAIL reset_preload: stall=%b busy=%h, required 1/00000018", dep_stall, sb_reg_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sb_reg_busy !== 32'h0 || dep_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: busy=%h stall=%b, required 0/0", sb_reg_busy, dep_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_raw_latency();
    clear_inputs();
    set_lane(0, 0, 0, 0, 0, 3, 5, 1, 0, 2);
    issue_req = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_fire !== 1'b1 || dep_stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_issue: fire=%b stall=%b, required 1/0", issue_fire, dep_stall);
    end
    tick();
    clear_inputs();
    issue_req = 1'b1;
    set_lane(2, 5, 1, 0, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dep_stall !== (i < 2) || issue_fire !== (i == 2)) begin
        errors++;
        $display("FAIL raw_cycle%0d: stall=%b fire=%b, required %b/%b", i, dep_stall, issue_fire, i < 2, i == 2);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_long();
    int bad;
    clear_inputs();
    set_lane(1, 0, 0, 0, 0, 3, 7, 1, 0, LONG);
    issue_req = 1'b1;
    tick();
    clear_inputs();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb_reg_busy[7] !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL long_hold: r7 idle in %0d of 50 cycles, required 0", bad);
    end
    wbv = 2'b10; wbn = {5'd7, 5'd0};
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (sb_reg_busy[7] !== 1'b0) begin
      errors++;
      $display("FAIL long_clear: r7 busy=%b, required 0", sb_reg_busy[7]);
    end
    tick();
    wbv = 2'b01; wbn = {5'd0, 5'd7};
    set_lane(0, 0, 0, 0, 0, 3, 7, 1, 0, 3);
    issue_req = 1'b1;
    tick();
    clear_inputs();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sb_reg_busy[7] !== (i < 3)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_vs_issue: %0d cycles deviate from 3-cycle busy window, required 0", bad);
    end
  endtask

  task automatic test_waw();
    clear_inputs();
    set_lane(0, 0, 0, 0, 0, 3, 9, 1, 0, 4);
    set_lane(3, 0, 0, 0, 0, 3, 9, 1, 0, 2);
    issue_req = 1'b1;
    @(negedge clk);
    checks++;
    if (waw_conflict !== 1'b1 || issue_fire !== 1'b0) begin
      errors++;
      $display("FAIL waw_reg: waw=%b fire=%b, required 1/0", waw_conflict, issue_fire);
    end
    tick();
    clear_inputs();
    set_lane(0, 0, 0, 0, 0, 3, 1, 0, 1, 4);
    set_lane(3, 0, 0, 0, 0, 3, 1, 0, 1, 4);
    issue_req = 1'b1;
    @(negedge clk);
    checks++;
    if (waw_conflict !== 1'b1 || issue_fire !== 1'b0 || sb_reg_busy[9] !== 1'b0) begin
      errors++;
      $display("FAIL waw_pred: waw=%b fire=%b r9=%b, required 1/0/0", waw_conflict, issue_fire, sb_reg_busy[9]);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (sb_pred_busy !== 3'b000 || sb_reg_busy !== 32'h0) begin
      errors++;
      $display("FAIL waw_state: pred=%b busy=%h, required 000/0", sb_pred_busy, sb_reg_busy);
    end
    tick();
  endtask

  task automatic test_pred();
    clear_inputs();
    set_lane(0, 0, 0, 0, 0, 3, 2, 0, 1, 1);
    issue_req = 1'b1;
    tick();
    clear_inputs();
    set_lane(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    issue_req = 1'b1;
    @(negedge clk);
    checks++;
    if (dep_stall !== 1'b1 || sb_pred_busy !== 3'b100) begin
      errors++;
      $display("FAIL pred_stall: stall=%b pred=%b, required 1/100", dep_stall, sb_pred_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dep_stall !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL pred_release: stall=%b fire=%b, required 0/1", dep_stall, issue_fire);
    end
    tick();
    clear_inputs();
    set_lane(0, 0, 0, 0, 0, 3, 3, 0, 1, 5);
    issue_req = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (dep_stall !== 1'b0 || issue_fire !== 1'b1 || sb_pred_busy !== 3'b000) begin
      errors++;
      $display("FAIL pred3: stall=%b fire=%b pred=%b, required 0/1/000", dep_stall, issue_fire, sb_pred_busy);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush();
    clear_inputs();
    issue_req = 1'b1;
    for (int p = 0; p < 3; p++) begin
      clear_inputs();
      issue_req = 1'b1;
      for (int l = 0; l < 4 && p * 4 + l < 10; l++)
        set_lane(l, 0, 0, 0, 0, 3, 10 + p * 4 + l, 1, 0, (l % 2 == 0) ? LONG : 6);
      if (p == 2) set_lane(2, 0, 0, 0, 0, 3, 0, 0, 1, LONG);
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if ($countones(sb_reg_busy) != 10 || sb_pred_busy !== 3'b001) begin
      errors++;
      $display("FAIL flush_preload: busy=%h pred=%b, required 10 bits/001", sb_reg_busy, sb_pred_busy);
    end
    flush = 1'b1;
    issue_req = 1'b1;
    set_lane(0, 0, 0, 0, 0, 3, 20, 1, 0, 5);
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (sb_reg_busy !== 32'h0 || sb_pred_busy !== 3'b000) begin
      errors++;
      $display("FAIL flush_clear: busy=%h pred=%b, required 0/000", sb_reg_busy, sb_pred_busy);
    end
    tick();
  endtask

  task automatic test_random();
    bit es, ew, ef;
    logic [31:0] eb;
    logic [2:0] ep;
    int lt;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      issue_req = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 49) == 0);
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 9) < 6) begin
          case ($urandom_range(0, 4))
            0: lt = 0;
            1: lt = 1;
            2: lt = $urandom_range(2, 6);
            3: lt = LONG;
            default: lt = $urandom_range(1, 3);
          endcase
          set_lane(l, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : 3,
                   $urandom_range(0, 9), $urandom_range(0, 1), ($urandom_range(0, 3) == 0), lt);
        end
      end
      for (int k = 0; k < NW; k++) begin
        wbv[k] = ($urandom_range(0, 2) == 0);
        wbp[k] = ($urandom_range(0, 3) == 0);
        wbn[k*5 +: 5] = 5'($urandom_range(0, 9));
      end
      @(negedge clk);
      model_eval(es, ew, ef, eb, ep);
      checks++;
      if (dep_stall !== es || waw_conflict !== ew || issue_fire !== ef) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: stall/waw/fire=%b%b%b, required %b%b%b", i, dep_stall, waw_conflict, issue_fire, es, ew, ef);
      end
      checks++;
      if (sb_reg_busy !== eb || sb_pred_busy !== ep) begin
        errors++;
        $display("FAIL rand_busy[%0d]: busy=%h pred=%b, required %h/%b", i, sb_reg_busy, sb_pred_busy, eb, ep);
      end
      @(posedge clk);
      model_commit(ef);
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_raw_latency();
    test_long();
    test_waw();
    test_pred();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
